// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: ALU ops, opcodes, FSM states and
// datapath select enums.
package rv_ctrl_pkg;

  // ALU operation codes, shared with alu
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSll  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluSlt  = 4'd8;
  localparam logic [3:0] AluSltu = 4'd9;

  localparam logic [6:0] OpcLoad   = 7'h03;
  localparam logic [6:0] OpcOpImm  = 7'h13;
  localparam logic [6:0] OpcAuipc  = 7'h17;
  localparam logic [6:0] OpcStore  = 7'h23;
  localparam logic [6:0] OpcOp     = 7'h33;
  localparam logic [6:0] OpcLui    = 7'h37;
  localparam logic [6:0] OpcBranch = 7'h63;
  localparam logic [6:0] OpcJalr   = 7'h67;
  localparam logic [6:0] OpcJal    = 7'h6f;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} ctrl_state_e;

  typedef enum logic [1:0] {ASelRs1, ASelPc, ASelZero, ASelOldPc} a_sel_e;
  typedef enum logic [1:0] {BSelRs2, BSelImm, BSelFour} b_sel_e;
  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;
  typedef enum logic [1:0] {PcAlu, PcAluOut, PcAluMasked} pc_src_e;
  typedef enum logic [1:0] {WbAluOut, WbMem, WbPc} wb_sel_e;

  typedef enum logic [3:0] {
    ClsOp, ClsOpImm, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsIllegal
  } instr_cls_e;

  // funct3 -> ALU op for register/immediate arithmetic; alt selects SUB/SRA
  function automatic logic [3:0] arith_op(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    unique case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational instruction decode: opcode/funct fields to instruction class, EXEC-stage
// ALU op and immediate format, and legality.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] cls,
  output logic [3:0] alu_op,
  output logic [2:0] imm_sel,
  output logic       legal
);

  logic is_shift;
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    cls     = ClsIllegal;
    alu_op  = AluAdd;
    imm_sel = ImmI;
    case (opcode)
      OpcOp: begin
        alu_op = arith_op(funct3, funct7[5]);
        if ((funct7 == 7'h00) ||
            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          cls = ClsOp;
        end
      end
      OpcOpImm: begin
        // Bit 30 is ordinary immediate data except on shifts, where it picks SRAI.
        alu_op = arith_op(funct3, is_shift && funct7[5]);
        if (funct3 == 3'b001) begin
          if (funct7 == 7'h00) cls = ClsOpImm;
        end else if (funct3 == 3'b101) begin
          if ((funct7 == 7'h00) || (funct7 == 7'h20)) cls = ClsOpImm;
        end else begin
          cls = ClsOpImm;
        end
      end
      OpcLoad:  cls = ClsLoad;
      OpcStore: begin
        cls     = ClsStore;
        imm_sel = ImmS;
      end
      OpcBranch: begin
        cls     = ClsBranch;
        imm_sel = ImmB;
        alu_op  = !funct3[2] ? AluSub : (funct3[1] ? AluSltu : AluSlt);
      end
      OpcJal: begin
        cls     = ClsJal;
        imm_sel = ImmJ;
      end
      OpcJalr:  cls = ClsJalr;
      OpcLui: begin
        cls     = ClsLui;
        imm_sel = ImmU;
      end
      OpcAuipc: begin
        cls     = ClsAuipc;
        imm_sel = ImmU;
      end
      default: cls = ClsIllegal;
    endcase
  end

  assign legal = (cls != ClsIllegal);

endmodule

// File: rtl/rv_control_fsm.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) driving ALU and datapath enables.
// Defining CTRL_PERF_COUNTERS_EN adds cycle_cnt/instret_cnt performance counters.
module rv_control_fsm
  import rv_ctrl_pkg::*;
`ifdef CTRL_PERF_COUNTERS_EN
#(
  parameter int unsigned PERF_W = 32
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lsb,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [2:0]  imm_sel,
  output logic        aluout_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        illegal
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instret_cnt
`endif
);

  ctrl_state_e state_q, state_d;
  instr_cls_e  cls;
  logic [3:0]  dec_cls, dec_alu_op;
  logic [2:0]  dec_imm_sel;
  logic        dec_legal, branch_taken;
  logic        unused_instr_bits;

  rv_ctrl_decode u_decode (
    .opcode  (instr[6:0]),
    .funct3  (instr[14:12]),
    .funct7  (instr[31:25]),
    .cls     (dec_cls),
    .alu_op  (dec_alu_op),
    .imm_sel (dec_imm_sel),
    .legal   (dec_legal)
  );

  assign cls               = instr_cls_e'(dec_cls);
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
  // funct3[2] picks the SLT/SLTU flag over zero; funct3[0] inverts the sense (BNE/BGE/BGEU)
  assign branch_taken      = (instr[14] ? alu_lsb : alu_zero) ^ instr[12];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PcAlu;
    alu_op    = AluAdd;
    alu_a_sel = ASelRs1;
    alu_b_sel = BSelRs2;
    imm_sel   = ImmI;
    aluout_we = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WbAluOut;
    retire    = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem_req   = 1'b1;
          alu_a_sel = ASelPc;
          alu_b_sel = BSelFour;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: begin
          alu_a_sel = ASelOldPc;
          alu_b_sel = BSelImm;
          imm_sel   = (cls == ClsJal) ? ImmJ : ImmB;
          aluout_we = 1'b1;
          state_d   = dec_legal ? StExec : StTrap;
        end
        StExec: begin
          alu_op  = dec_alu_op;
          imm_sel = dec_imm_sel;
          case (cls)
            ClsOp: begin
              aluout_we = 1'b1;
              state_d   = StWb;
            end
            ClsOpImm, ClsLoad, ClsStore: begin
              alu_b_sel = BSelImm;
              aluout_we = 1'b1;
              state_d   = (cls == ClsOpImm) ? StWb : StMem;
            end
            ClsBranch: begin
              pc_we   = branch_taken;
              pc_src  = PcAluOut;
              retire  = 1'b1;
              state_d = StFetch;
            end
            ClsJal, ClsJalr: begin
              alu_b_sel = (cls == ClsJalr) ? BSelImm : BSelRs2;
              pc_src    = (cls == ClsJalr) ? PcAluMasked : PcAluOut;
              pc_we     = 1'b1;
              rf_we     = 1'b1;
              wb_sel    = WbPc;
              retire    = 1'b1;
              state_d   = StFetch;
            end
            ClsLui, ClsAuipc: begin
              alu_a_sel = (cls == ClsLui) ? ASelZero : ASelOldPc;
              alu_b_sel = BSelImm;
              aluout_we = 1'b1;
              state_d   = StWb;
            end
            default: state_d = StTrap;
          endcase
        end
        StMem: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (cls == ClsStore);
          if (mem_ready) begin
            retire  = (cls == ClsStore);
            state_d = (cls == ClsStore) ? StFetch : StWb;
          end
        end
        StWb: begin
          rf_we   = 1'b1;
          wb_sel  = (cls == ClsLoad) ? WbMem : WbAluOut;
          retire  = 1'b1;
          state_d = StFetch;
        end
        StTrap:  illegal = 1'b1;
        default: state_d = StFetch;
      endcase
    end
  end

`ifdef CTRL_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (state_q != StTrap) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/rv_control_fsm.md
# rv_control_fsm

Multi-cycle RV32I control unit that sits directly upstream of `alu`. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the ALU's `alu_op` and operand selects. It also drives the register-file, PC, IR and memory enables, and closes branches using the ALU's `zero_flag` and `result[0]`.

## Interface
- `PERF_W`, 32, width of performance counters (used only with `CTRL_PERF_COUNTERS_EN`)
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `instr` in 32: IR contents, valid from DECODE onward
- `mem_ready` in 1: memory completion; sampled only while `mem_req`=1
- `alu_zero` in 1: ALU `zero_flag`
- `alu_lsb` in 1: ALU `result[0]`
- `mem_req` out 1: memory request
- `mem_we` out 1: store
- `addr_sel` out 1: memory address source; 0=PC, 1=ALUOut reg
- `ir_we` out 1: IR load enable
- `pc_we` out 1: PC load enable
- `pc_src` out 2: PC source; 0=ALU result, 1=ALUOut reg, 2=ALU result & ~1
- `alu_op` out 4: ALU operation
- `alu_a_sel` out 2: ALU A operand; 0=rs1, 1=PC, 2=zero, 3=oldPC
- `alu_b_sel` out 2: ALU B operand; 0=rs2, 1=imm, 2=const 4
- `imm_sel` out 3: immediate format; 0=I, 1=S, 2=B, 3=U, 4=J
- `aluout_we` out 1: ALUOut reg load enable
- `rf_we` out 1: register-file write enable
- `wb_sel` out 2: writeback source; 0=ALUOut, 1=mem data, 2=PC
- `retire` out 1: 1-cycle pulse on an instruction's final cycle
- `illegal` out 1: high while in TRAP
- `cycle_cnt`, `instret_cnt` out PERF_W: present only with the macro

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is FETCH.
- While `rst`=1 every output is forced to 0.
- FETCH:
  - Drive `mem_req`=1, `addr_sel`=0, ALU computes PC+4 (a=1, b=2, ADD).
  - Hold until `mem_ready`. On the ready cycle assert `ir_we` and `pc_we` (pc_src=0); the datapath latches oldPC. Next state: DECODE.
- DECODE:
  - Compute oldPC+imm into ALUOut (a=3, b=1, imm_sel=B or J by opcode, `aluout_we`).
  - Decode the opcode. Unknown opcode, or a bad funct for OP/OP-IMM, goes to TRAP; otherwise EXEC.
- EXEC, per opcode:
  - OP: a=0, b=0. alu_op from funct3, with funct7[5] selecting SUB or SRA. `aluout_we`. Next: WB.
  - OP-IMM: same, but b=1 and imm_sel=I. funct7[5] is honoured only for shifts (SRAI). Next: WB.
  - LOAD/STORE: ADD, b=1, imm_sel I or S. `aluout_we`. Next: MEM.
  - BRANCH: BEQ/BNE use SUB and take on `alu_zero` / !`alu_zero`. BLT/BGE use SLT; BLTU/BGEU use SLTU; both take on `alu_lsb` / !`alu_lsb`. When taken: `pc_we`, pc_src=1. Then `retire` and go to FETCH.
  - JAL: `pc_we` with pc_src=1, plus `rf_we` with wb_sel=2 in the same cycle (writes PC+4). `retire`, go to FETCH.
  - JALR: a=0, b=1, ADD, pc_src=2; `pc_we` and `rf_we` with wb_sel=2. `retire`, go to FETCH.
  - LUI: a=2, b=1, imm_sel=U. Next: WB.
  - AUIPC: a=3, b=1, imm_sel=U. Next: WB.
- MEM:
  - Drive `mem_req`, `addr_sel`=1, and `mem_we` for stores. Hold until `mem_ready`.
  - Store: `retire`, go to FETCH. Load: go to WB.
- WB: `rf_we`, wb_sel=1 for loads and 0 otherwise. `retire`, go to FETCH.
- TRAP: terminal. `illegal`=1 and all other outputs 0 until reset.
- `alu_op` encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.

## Timing
- State register is updated on the `clk` rising edge; outputs are combinational from state, `instr` and the ALU flags.
- Cycles per instruction with zero-wait memory: branch/JAL/JALR 3; store 4; ALU/LUI/AUIPC 4; load 5. Each memory wait cycle adds 1.
- `mem_ready` in the same cycle that `mem_req` rises completes with zero wait.
- `rst` asserted mid-instruction takes effect immediately: return to FETCH, no write enable asserted, counters cleared.

## Configuration
- `CTRL_PERF_COUNTERS_EN` defined:
  - `cycle_cnt` increments every clock out of reset.
  - `instret_cnt` increments on `retire`.
  - Both wrap modulo 2^PERF_W, reset to 0, and stop counting in TRAP.
- Undefined: the counter ports and logic are absent.

## Structure
- Package `rv_ctrl_pkg` holds: the ALU op localparams (shared with `alu`), the opcode constants, the state enum, and the select-encoding enums.
- One sub-module, `rv_ctrl_decode`: combinational opcode/funct → alu_op, imm_sel, legality.

## Test plan
- ADD x3,x1,x2 (0x002081B3), zero-wait memory → FETCH, DECODE, EXEC, WB over 4 cycles; in EXEC alu_op=0, a=0, b=0; `rf_we`, wb_sel=0 and `retire` in WB.
- SRAI (funct7=0x20, funct3=101, opcode 0x13) → alu_op=7, b=1, imm_sel=0.
- BNE with `alu_zero`=0 → alu_op=1 and `pc_we`=1 in EXEC; with `alu_zero`=1, `pc_we`=0. Both cases take 3 cycles.
- LW with `mem_ready` held low 2 cycles in MEM → 7 cycles total; `addr_sel`=1 throughout MEM; wb_sel=1 in WB.
- Opcode 0x7F → `illegal`=1 from the cycle after DECODE; all other outputs stay 0 until reset; `rst` pulse returns the FSM to FETCH.
- `rst` asserted during MEM of a store → outputs 0 immediately, `mem_we` never pulses, counters (when enabled) read 0.
